// File: rtl/fifo_rr_packet_arbiter_pkg.sv
// rtl/fifo_rr_packet_arbiter_pkg.sv - shared state encodings and width helper for the packet arbiter
package fifo_rr_packet_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_e;

  // Never returns less than 1 so a derived index field is always at least one bit wide.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/fifo_rr_packet_arbiter_if.sv
// rtl/fifo_rr_packet_arbiter_if.sv - FIFO-side and output-stream signals of the packet arbiter
interface fifo_rr_packet_arbiter_if #(
  parameter int NUM_QUEUES = 4,
  parameter int WIDTH      = 72,
  parameter int QUEUE_BITS = 2
);

  logic [NUM_QUEUES*WIDTH-1:0] in_dout;
  logic [NUM_QUEUES-1:0]       in_eop;
  logic [NUM_QUEUES-1:0]       in_empty;
  logic [NUM_QUEUES-1:0]       in_rd_en;
  logic [NUM_QUEUES-1:0]       queue_enable;
  logic [WIDTH-1:0]            out_data;
  logic                        out_eop;
  logic [QUEUE_BITS-1:0]       out_src;
  logic                        out_valid;
  logic                        out_ready;
  logic                        busy;

  modport master (
    input  in_dout, in_eop, in_empty, queue_enable, out_ready,
    output in_rd_en, out_data, out_eop, out_src, out_valid, busy
  );

  modport slave (
    output in_dout, in_eop, in_empty, queue_enable, out_ready,
    input  in_rd_en, out_data, out_eop, out_src, out_valid, busy
  );

endinterface

// File: rtl/fifo_rr_packet_arbiter_rr_priority_picker.sv
// rtl/fifo_rr_packet_arbiter_rr_priority_picker.sv - combinational round-robin pick starting after last_grant
module rr_priority_picker
  import fifo_rr_packet_arbiter_pkg::*;
#(
  parameter int NUM_QUEUES = 4,
  parameter int QUEUE_BITS = clog2(NUM_QUEUES)
) (
  input  logic [NUM_QUEUES-1:0] req,
  input  logic [QUEUE_BITS-1:0] last_grant,
  output logic                  found,
  output logic [QUEUE_BITS-1:0] next_grant
);

  logic [QUEUE_BITS-1:0] idx;

  always_comb begin
    found      = 1'b0;
    next_grant = '0;
    idx        = '0;
    // Walk from the farthest candidate inward so the nearest requester after last_grant wins.
    for (int k = NUM_QUEUES; k >= 1; k--) begin
      idx = QUEUE_BITS'((int'(last_grant) + k) % NUM_QUEUES);
      if (req[idx]) begin
        found      = 1'b1;
        next_grant = idx;
      end
    end
  end

endmodule

// File: rtl/fifo_rr_packet_arbiter.sv
// rtl/fifo_rr_packet_arbiter.sv - packet-aware round-robin drain of fallthrough FIFOs into one registered stream
module fifo_rr_packet_arbiter
  import fifo_rr_packet_arbiter_pkg::*;
#(
  parameter int NUM_QUEUES = 4,
  parameter int WIDTH      = 72,
  parameter int QUEUE_BITS = clog2(NUM_QUEUES)
) (
  input  logic                     clk,
  input  logic                     reset,
  fifo_rr_packet_arbiter_if.master bus
);

  state_e                state_q, state_d;
  logic [QUEUE_BITS-1:0] grant_q, grant_d;
  logic [QUEUE_BITS-1:0] last_grant_q, last_grant_d;
  logic [NUM_QUEUES-1:0] req;
  logic                  found;
  logic [QUEUE_BITS-1:0] next_grant;
  logic [WIDTH-1:0]      head_data;
  logic                  head_eop;
  logic                  head_empty;
  logic                  pop;

  // Enable mask only matters when choosing a new packet; an open packet always completes.
  assign req = ~bus.in_empty & bus.queue_enable;

  rr_priority_picker #(
    .NUM_QUEUES(NUM_QUEUES),
    .QUEUE_BITS(QUEUE_BITS)
  ) u_picker (
    .req       (req),
    .last_grant(last_grant_q),
    .found     (found),
    .next_grant(next_grant)
  );

  always_comb begin
    head_data = '0;
    for (int i = 0; i < NUM_QUEUES; i++) begin
      if (grant_q == QUEUE_BITS'(i)) head_data = bus.in_dout[i*WIDTH +: WIDTH];
    end
    head_eop   = bus.in_eop[grant_q];
    head_empty = bus.in_empty[grant_q];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= QUEUE_BITS'(NUM_QUEUES - 1);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    pop          = 1'b0;
    bus.in_rd_en = '0;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          grant_d = next_grant;
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        // Reset gating keeps the owner's FIFOs intact while we are being cleared.
        pop = ~head_empty & (~bus.out_valid | bus.out_ready) & ~reset;
        if (pop) begin
          bus.in_rd_en[grant_q] = 1'b1;
          if (head_eop) begin
            last_grant_d = grant_q;
            state_d      = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_eop   <= 1'b0;
      bus.out_src   <= '0;
    end else if (pop) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= head_data;
      bus.out_eop   <= head_eop;
      bus.out_src   <= grant_q;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

  assign bus.busy = (state_q == ST_XFER);

endmodule

// File: doc/fifo_rr_packet_arbiter.md
Name: fifo_rr_packet_arbiter

Overview:
- Round-robin, packet-aware scheduler that drains NUM_QUEUES fallthrough small FIFOs into one registered output stream.
- Holds a grant for a whole packet (until an end-of-packet word is popped), then moves to the next non-empty enabled queue.
- Sits between per-port fallthrough_small_fifo instances and a shared downstream datapath, in a single clock domain.

Parameters:
- NUM_QUEUES, 4, number of input FIFOs (2..16).
- WIDTH, 72, data word width.
- QUEUE_BITS, 2, log2(NUM_QUEUES); width of the source index.

Ports:
- clk  input  1  sole clock.
- reset  input  1  synchronous, active-high reset.
- in_dout  input  NUM_QUEUES*WIDTH  fallthrough data of each FIFO; queue i occupies bits [i*WIDTH +: WIDTH].
- in_eop  input  NUM_QUEUES  end-of-packet flag of each FIFO head word.
- in_empty  input  NUM_QUEUES  FIFO empty flags.
- in_rd_en  output  NUM_QUEUES  pop strobes, one-hot or zero.
- queue_enable  input  NUM_QUEUES  per-queue arbitration enable.
- out_data  output  WIDTH  registered data.
- out_eop  output  1  registered end-of-packet.
- out_src  output  QUEUE_BITS  index of the queue that sourced out_data.
- out_valid  output  1  out_data, out_eop and out_src are valid.
- out_ready  input  1  downstream accepts when out_valid and out_ready are both high.
- busy  output  1  high while in XFER.

Behaviour:
- Reset, synchronous:
  - state=IDLE, grant=0, last_grant=NUM_QUEUES-1, so queue 0 has top priority after reset.
  - out_valid=0, out_data=0, out_eop=0, out_src=0, in_rd_en=0, busy=0.
  - FIFO contents are not touched; the FIFOs are reset by their owner.
- State IDLE:
  - req[i] = ~in_empty[i] & queue_enable[i].
  - If any req is set: grant = first i with req[i] set, searching from last_grant+1 upward with wrap-around. Go to XFER next cycle. No pop occurs in IDLE.
  - Otherwise stay in IDLE.
- State XFER:
  - pop = ~in_empty[grant] & (~out_valid | out_ready).
  - in_rd_en[grant] = pop, combinational. All other rd_en bits are 0.
  - On pop, the output register loads in_dout[grant], in_eop[grant] and grant at the next edge; out_valid=1.
  - If out_ready is high and no pop occurs, out_valid goes to 0.
  - On pop with in_eop[grant]=1: last_grant<=grant, state<=IDLE.
- Latency and throughput:
  - A word appears at the output 1 cycle after its pop.
  - Full throughput inside a packet: one word per cycle while out_ready is high.
  - One IDLE bubble cycle between packets.
- Output stability: while out_valid=1 and out_ready=0, out_data, out_eop and out_src are held stable and no pop occurs.
- Granted queue goes empty mid-packet: stay in XFER, hold the grant, pop nothing; other queues are not served.
- queue_enable[grant] deasserted mid-packet: the current packet completes; the mask is applied only in IDLE.
- Simultaneous requests: round-robin only, no fixed priority apart from the post-reset pointer.
- Single requester: the same queue is re-granted after each one-cycle IDLE.
- Reset asserted mid-packet: immediate return to reset values; the partial packet is abandoned downstream and is the owner's concern.
- grant and out_src are QUEUE_BITS wide. Wrap-around is computed modulo NUM_QUEUES, so non-power-of-2 values are legal.

Decomposition:
- Shared package/header: state encodings ST_IDLE=1'b0 and ST_XFER=1'b1, plus a clog2 function for derived widths.
- One sub-module, rr_priority_picker:
  - Combinational.
  - Inputs: req[NUM_QUEUES], last_grant.
  - Outputs: found, next_grant.
  - Unit-testable on its own.
- The FSM, pop logic and output register stay in fifo_rr_packet_arbiter.

Test Plan:
- Reset, then all queues empty for 10 cycles -> out_valid=0, in_rd_en=0, busy=0 throughout.
- Q0 holds a 3-word packet (A0, A1, A2 with eop), out_ready=1 -> in_rd_en=0001 for 3 consecutive cycles; out_data=A0, A1, A2 on the following 3 cycles with out_src=0 and out_eop only on A2; then IDLE.
- Q1 and Q3 each hold 2-word packets, last_grant=0 -> Q1's packet emitted fully, then Q3's; out_src sequence 1,1,3,3; no interleaving.
- Q2 is granted; after 1 word it goes empty for 4 cycles, then refills with the eop word while Q0 is non-empty -> no pops during the 4-cycle gap; Q2's eop word emitted before any Q0 word.
- out_ready held low for 5 cycles while the output holds D1 -> out_data=D1 stable, in_rd_en=0; when out_ready rises, the next word appears 1 cycle later.
- Reset asserted during word 2 of a 4-word packet on Q1 -> next cycle out_valid=0, in_rd_en=0, state IDLE; with Q0 and Q1 both non-empty, the next grant is Q0.
